// File: rtl/encoder_4x2_pending.sv
// Registered 4-to-2 priority encoder: latches rising request edges into pending
// flags and presents the highest pending index until the consumer acknowledges.
module encoder_4x2_pending (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [0:3] D,
    input  logic       ack,
    output logic       A,
    output logic       B,
    output logic       V,
    output logic [0:3] P
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [0:3] d_q;
    logic [0:3] p_q, p_d;
    logic [1:0] code_q, code_d;
    logic [1:0] enc;
    logic       grant_done;

    assign grant_done = (state_q == HOLD) && ack;

    // Set has priority over clear, so a re-request on the ack edge is served again.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pending
            logic set_bit;
            logic clr_bit;
            assign set_bit = enable && D[gi] && !d_q[gi];
            assign clr_bit = grant_done && (code_q == 2'(gi));
            assign p_d[gi] = set_bit || (p_q[gi] && !clr_bit);
        end
    endgenerate

    always_comb begin
        enc = 2'd0;
        if (p_q[3])      enc = 2'd3;
        else if (p_q[2]) enc = 2'd2;
        else if (p_q[1]) enc = 2'd1;
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (|p_q) begin
                    code_d  = enc;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            d_q     <= 4'b0000;
            p_q     <= 4'b0000;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            d_q     <= D;
            p_q     <= p_d;
            code_q  <= code_d;
        end
    end

    assign A = code_q[1];
    assign B = code_q[0];
    assign V = (state_q == HOLD);
    assign P = p_q;

endmodule

// File: tb/tb_encoder_4x2_pending.sv
// Directed bench for encoder_4x2_pending; outputs are sampled 1 time unit after each rising edge.
module tb_encoder_4x2_pending;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic [0:3] D = 4'b0000;
    logic       ack = 1'b0;
    logic       A, B, V;
    logic [0:3] P;

    int checks = 0;
    int errors = 0;

    encoder_4x2_pending dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .D      (D),
        .ack    (ack),
        .A      (A),
        .B      (B),
        .V      (V),
        .P      (P)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %b expected %b", tag, obs, exp);
        end else begin
            $display("ok   %s = %b", tag, obs);
        end
    endtask

    // Checks P and V always; the code only while it is valid.
    task automatic expect_out(input string tag, input logic [3:0] exp_p,
                              input logic exp_v, input logic [1:0] exp_code);
        check({tag, ".P"}, P, exp_p);
        check({tag, ".V"}, {3'b000, V}, {3'b000, exp_v});
        if (exp_v) check({tag, ".code"}, {2'b00, A, B}, {2'b00, exp_code});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset asserted before any clock edge must clear everything.
        D = 4'b1111;
        #1 reset = 1'b1;
        #1;
        check("rst_async.code", {2'b00, A, B}, 4'b0000);
        expect_out("rst_async", 4'b0000, 1'b0, 2'b00);
        tick();
        tick();
        expect_out("rst_held", 4'b0000, 1'b0, 2'b00);
        reset = 1'b0;
        tick();
        expect_out("rel_capture", 4'b1111, 1'b0, 2'b00);
        tick();
        expect_out("rel_grant3", 4'b1111, 1'b1, 2'b11);
        ack = 1'b1;
        tick();
        expect_out("drain_ack3", 4'b1110, 1'b0, 2'b00);
        tick();
        expect_out("drain_idle_ack_ignored", 4'b1110, 1'b1, 2'b10);
        tick();
        expect_out("drain_ack2", 4'b1100, 1'b0, 2'b00);
        tick();
        expect_out("drain_grant1", 4'b1100, 1'b1, 2'b01);
        tick();
        expect_out("drain_ack1", 4'b1000, 1'b0, 2'b00);
        tick();
        expect_out("drain_grant0", 4'b1000, 1'b1, 2'b00);
        tick();
        expect_out("drain_ack0", 4'b0000, 1'b0, 2'b00);
        ack = 1'b0;
        tick();
        tick();
        expect_out("held_no_retrigger", 4'b0000, 1'b0, 2'b00);

        // Single one-cycle pulse on D[1].
        D = 4'b0000;
        tick();
        D = 4'b0100;
        tick();
        expect_out("single_capture", 4'b0100, 1'b0, 2'b00);
        D = 4'b0000;
        tick();
        expect_out("single_grant", 4'b0100, 1'b1, 2'b01);
        ack = 1'b1;
        tick();
        expect_out("single_ack", 4'b0000, 1'b0, 2'b00);
        ack = 1'b0;

        // Priority, then a higher request during HOLD does not preempt.
        D = 4'b1010;
        tick();
        expect_out("prio_capture", 4'b1010, 1'b0, 2'b00);
        D = 4'b0000;
        tick();
        expect_out("prio_grant2", 4'b1010, 1'b1, 2'b10);
        D = 4'b0001;
        tick();
        expect_out("prio_no_preempt", 4'b1011, 1'b1, 2'b10);
        D = 4'b0000;
        ack = 1'b1;
        tick();
        expect_out("prio_ack2", 4'b1001, 1'b0, 2'b00);
        ack = 1'b0;
        tick();
        expect_out("prio_grant3", 4'b1001, 1'b1, 2'b11);
        ack = 1'b1;
        tick();
        expect_out("prio_ack3", 4'b1000, 1'b0, 2'b00);
        ack = 1'b0;
        tick();
        expect_out("prio_grant0", 4'b1000, 1'b1, 2'b00);
        ack = 1'b1;
        tick();
        expect_out("prio_ack0", 4'b0000, 1'b0, 2'b00);
        ack = 1'b0;

        // Enable gating: one-hot walk with B every 10 cycles, A every 20.
        enable = 1'b0;
        for (int c = 0; c < 40; c++) begin
            logic [1:0] idx;
            logic [3:0] oh;
            idx = {1'((c / 20) % 2), 1'((c / 10) % 2)};
            oh  = 4'b1000 >> idx;
            D   = oh;
            tick();
            if (c % 10 == 9) expect_out($sformatf("gated_c%0d", c), 4'b0000, 1'b0, 2'b00);
        end
        D = 4'b0010;
        tick();
        enable = 1'b1;
        tick();
        expect_out("en_on_held_level", 4'b0000, 1'b0, 2'b00);
        tick();
        expect_out("en_on_held_level2", 4'b0000, 1'b0, 2'b00);
        D = 4'b0000;
        tick();
        D = 4'b0010;
        tick();
        expect_out("en_new_rise", 4'b0010, 1'b0, 2'b00);
        tick();
        expect_out("en_grant2", 4'b0010, 1'b1, 2'b10);
        ack = 1'b1;
        tick();
        expect_out("en_ack2", 4'b0000, 1'b0, 2'b00);
        ack = 1'b0;
        D = 4'b0000;

        // Set/clear collision on the same bit.
        tick();
        D = 4'b0100;
        tick();
        D = 4'b0000;
        tick();
        expect_out("coll_grant1", 4'b0100, 1'b1, 2'b01);
        D = 4'b0100;
        ack = 1'b1;
        tick();
        expect_out("coll_set_wins", 4'b0100, 1'b0, 2'b00);
        D = 4'b0000;
        ack = 1'b0;
        tick();
        expect_out("coll_regrant1", 4'b0100, 1'b1, 2'b01);
        ack = 1'b1;
        tick();
        expect_out("coll_ack1", 4'b0000, 1'b0, 2'b00);
        ack = 1'b0;

        // Reset between edges while holding code 2 with P=1010.
        D = 4'b1010;
        tick();
        tick();
        expect_out("mid_hold", 4'b1010, 1'b1, 2'b10);
        #2 reset = 1'b1;
        #1;
        check("mid_rst.code", {2'b00, A, B}, 4'b0000);
        expect_out("mid_rst", 4'b0000, 1'b0, 2'b00);
        tick();
        reset = 1'b0;
        tick();
        expect_out("mid_recapture", 4'b1010, 1'b0, 2'b00);
        tick();
        expect_out("mid_regrant2", 4'b1010, 1'b1, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
